// File: rtl/trace_pkg.sv
// trace_pkg: shared types, constants and helpers for the pipeline trace transmitter
package trace_pkg;
   localparam logic [7:0] HDR_MAGIC = 8'hA5;
   typedef enum logic [1:0] {HDR, CYC, PC, CNT} word_e;
   typedef enum logic {IDLE, SEND} state_e;
   typedef struct packed {
      logic [7:0]  seq;
      logic [15:0] drop;
      logic [31:0] cyc;
      logic [31:0] pc;
      logic [15:0] stl;
      logic [15:0] fls;
   } rec_t;
   function automatic logic [15:0] sat16(input logic [31:0] v);
      return (|v[31:16]) ? 16'hFFFF : v[15:0];
   endfunction
   function automatic logic [31:0] rec_word(input rec_t r, input word_e w);
      return (w == HDR) ? {HDR_MAGIC, r.seq, r.drop} : (w == CYC) ? r.cyc : (w == PC) ? r.pc : {r.stl, r.fls};
   endfunction
endpackage

// File: rtl/pipe_trace_tx_if.sv
// pipe_trace_tx_if: 32-bit valid/ready trace word stream
interface pipe_trace_tx_if;
   logic [31:0] data;
   logic        valid;
   logic        ready;
   modport master (output data, output valid, input ready);
   modport slave (input data, input valid, output ready);
endinterface

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous record FIFO exposing head and the entry behind it
module trace_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  logic pop_i,
   input  rec_t wdata_i,
   output rec_t head_o,
   output rec_t second_o,
   output logic empty_o,
   output logic full_o,
   output logic single_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   rec_t mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   // pointer and occupancy update; push and pop may coincide even when full
   always_comb begin
      wr_d = push_i ? wr_q + 1'b1 : wr_q;
      rd_d = pop_i ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
   end
   // pointer and occupancy registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   // record storage needs no reset, occupancy guards it
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= wdata_i;
   end
   assign head_o = mem_q[rd_q];
   assign second_o = mem_q[rd_q + 1'b1];
   assign empty_o = (cnt_q == '0);
   assign full_o = (cnt_q == (AW+1)'(DEPTH));
   assign single_o = (cnt_q == (AW+1)'(1));
endmodule

// File: rtl/pipe_trace_tx.sv
// pipe_trace_tx: counts pipeline cycles/stalls/flushes and streams periodic snapshot records
module pipe_trace_tx
   import trace_pkg::*;
#(
   parameter int PERIOD = 8,
   parameter int DEPTH  = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [31:0]     pc_i,
   input  logic            stall_i,
   input  logic            branch_i,
   input  logic            flush_i,
   pipe_trace_tx_if.master tx,
   output logic            overflow_o
);
   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   logic [31:0] cyc_q, cyc_d, stl_q, stl_d, fls_q, fls_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [7:0] seq_q, seq_d;
   logic [15:0] drop_q, drop_d;
   logic ovf_q, ovf_d;
   state_e state_q, state_d;
   word_e idx_q, idx_d;
   logic valid_q, valid_d;
   logic [31:0] data_q, data_d;
   logic cap, push, pop, hs, full, empty, single;
   rec_t rec, head, second, nxt_rec;

   trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_i   (push),
      .pop_i    (pop),
      .wdata_i  (rec),
      .head_o   (head),
      .second_o (second),
      .empty_o  (empty),
      .full_o   (full),
      .single_o (single)
   );

   assign hs = valid_q && tx.ready;
   assign pop = hs && (idx_q == CNT);

   // counters, capture decision and the snapshot record; a full FIFO still accepts when its head leaves this edge
   always_comb begin
      cyc_d = cyc_q + 32'(start_i);
      stl_d = stl_q + 32'(start_i && stall_i && !branch_i);
      fls_d = fls_q + 32'(flush_i && start_i);
      cap = start_i && (phase_q == PW'(PERIOD - 1));
      phase_d = !start_i ? phase_q : cap ? '0 : phase_q + 1'b1;
      push = cap && (!full || pop);
      seq_d = seq_q + 8'(push);
      drop_d = push ? '0 : cap ? ((drop_q == 16'hFFFF) ? drop_q : drop_q + 1'b1) : drop_q;
      ovf_d = ovf_q || (cap && !push);
      rec = '{seq: seq_q, drop: drop_q, cyc: cyc_q, pc: pc_i, stl: sat16(stl_d), fls: sat16(fls_d)};
   end

   // counter and capture registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cyc_q <= '0;
         stl_q <= '0;
         fls_q <= '0;
         phase_q <= '0;
         seq_q <= '0;
         drop_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cyc_q <= cyc_d;
         stl_q <= stl_d;
         fls_q <= fls_d;
         phase_q <= phase_d;
         seq_q <= seq_d;
         drop_q <= drop_d;
         ovf_q <= ovf_d;
      end
   end

   // serialiser state register with registered stream outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q <= HDR;
         valid_q <= 1'b0;
         data_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         valid_q <= valid_d;
         data_q <= data_d;
      end
   end

   // serialiser next state: leave SEND only when the last record leaves with nothing arriving
   always_comb begin
      state_d = (state_q == IDLE) ? (empty ? IDLE : SEND) : (pop && single && !push) ? IDLE : SEND;
   end

   // serialiser outputs: preload the next word so data is ready the cycle after each handshake
   always_comb begin
      nxt_rec = single ? rec : second;
      idx_d = (state_q == IDLE || pop) ? HDR : hs ? word_e'(idx_q + 2'd1) : idx_q;
      valid_d = (state_d == SEND);
      data_d = (state_q == IDLE) ? (empty ? data_q : rec_word(head, HDR))
             : pop ? ((state_d == SEND) ? rec_word(nxt_rec, HDR) : data_q)
             : hs ? rec_word(head, word_e'(idx_q + 2'd1)) : data_q;
   end

   assign tx.data = data_q;
   assign tx.valid = valid_q;
   assign overflow_o = ovf_q;
endmodule

// File: tb/tb_pipe_trace_tx.sv
// tb_pipe_trace_tx: directed and randomized checks of the trace transmitter against a record-level model
module tb_pipe_trace_tx;
   localparam int PERIOD = 8;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst_i, start_i, stall_i, branch_i, flush_i, overflow_o;
   logic [31:0] pc_i;
   int checks = 0;
   int failures = 0;
   logic [31:0] m_cyc, m_stl, m_fls, lat_hdr;
   int m_phase, m_seq, m_drop, m_occ, n_words, lat;
   bit m_ovf;
   logic [31:0] exp_q[$];
   logic [31:0] log_q[$];

   pipe_trace_tx_if tx();

   pipe_trace_tx #(.PERIOD(PERIOD), .DEPTH(DEPTH)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .pc_i       (pc_i),
      .stall_i    (stall_i),
      .branch_i   (branch_i),
      .flush_i    (flush_i),
      .tx         (tx),
      .overflow_o (overflow_o)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] s16(input logic [31:0] v);
      return (v > 32'h0000FFFF) ? 16'hFFFF : v[15:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock: model what the coming edge must do, then inspect the DUT at the following negedge
   task automatic step();
      logic [31:0] nstl, nfls, pd;
      bit hs, popped, hold;
      hs = (tx.valid === 1'b1) && tx.ready;
      popped = 1'b0;
      if (rst_i) begin
         m_cyc = '0; m_stl = '0; m_fls = '0;
         m_phase = 0; m_seq = 0; m_drop = 0; m_occ = 0; m_ovf = 1'b0;
         n_words = 0; lat = 0;
         exp_q.delete();
      end else begin
         if (hs) begin
            chk("word_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               chk("word", tx.data, exp_q[0]);
               void'(exp_q.pop_front());
            end
            log_q.push_back(tx.data);
            n_words++;
            popped = (n_words % 4 == 0);
            if (popped && m_occ > 0) m_occ--;
         end
         if (start_i) begin
            nstl = m_stl + 32'(stall_i && !branch_i);
            nfls = m_fls + 32'(flush_i);
            if (m_phase == PERIOD - 1) begin
               if (m_occ < DEPTH) begin
                  if (m_occ == 0 && !popped) begin
                     lat = 2;
                     lat_hdr = {8'hA5, 8'(m_seq), 16'(m_drop)};
                  end
                  exp_q.push_back({8'hA5, 8'(m_seq), 16'(m_drop)});
                  exp_q.push_back(m_cyc);
                  exp_q.push_back(pc_i);
                  exp_q.push_back({s16(nstl), s16(nfls)});
                  m_occ++;
                  m_seq++;
                  m_drop = 0;
               end else begin
                  if (m_drop < 65535) m_drop++;
                  m_ovf = 1'b1;
               end
               m_phase = 0;
            end else begin
               m_phase++;
            end
            m_cyc++;
            m_stl = nstl;
            m_fls = nfls;
         end
      end
      hold = (tx.valid === 1'b1) && !tx.ready && !rst_i;
      pd = tx.data;
      @(posedge clk);
      @(negedge clk);
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      if (rst_i) begin
         chk("rst_valid", 32'(tx.valid), 32'd0);
         chk("rst_data", tx.data, 32'd0);
      end
      if (hold) begin
         chk("hold_valid", 32'(tx.valid), 32'd1);
         chk("hold_data", tx.data, pd);
      end
      if (lat == 1) begin
         chk("lat_valid", 32'(tx.valid), 32'd1);
         chk("lat_hdr", tx.data, lat_hdr);
         lat = 0;
      end else if (lat == 2) begin
         chk("lat_idle", 32'(tx.valid), 32'd0);
         lat = 1;
      end
      if (tx.valid === 1'b1) chk("valid_pending", 32'(exp_q.size() > 0), 32'd1);
   endtask

   task automatic drive(input bit st, input bit rdy, input bit stl, input bit br, input bit fl);
      start_i = st;
      tx.ready = rdy;
      stall_i = stl;
      branch_i = br;
      flush_i = fl;
      pc_i = m_cyc * 4;
      step();
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_i = 1'b0;
      log_q.delete();
   endtask

   task automatic chk_log(input string tag, input int i, input logic [31:0] exp);
      chk(tag, (log_q.size() > i) ? log_q[i] : 32'hDEADBEEF, exp);
   endtask

   initial begin
      int k;
      rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0; flush_i = 1'b0;
      pc_i = '0; tx.ready = 1'b0; m_cyc = '0; lat = 0; n_words = 0;
      // reset, then idle with start low
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         chk("idle_valid", 32'(tx.valid), 32'd0);
      end
      // basic stream, pc = 4*cyc
      do_reset();
      for (int i = 0; i < 30; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_log("basic_w0", 0, 32'hA5000000);
      chk_log("basic_w1", 1, 32'd7);
      chk_log("basic_w2", 2, 32'd28);
      chk_log("basic_w3", 3, 32'h00000000);
      chk_log("basic_r1w0", 4, 32'hA5010000);
      chk_log("basic_r1w1", 5, 32'd15);
      chk_log("basic_r1w2", 6, 32'd60);
      chk_log("basic_r1w3", 7, 32'h00000000);
      // event counting in the first period
      do_reset();
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_log("event_w0", 0, 32'hA5000000);
      chk_log("event_w3", 3, 32'h00030002);
      // overflow with the consumer stalled for 64 cycles
      do_reset();
      for (int i = 0; i < 64; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovf_set", 32'(overflow_o), 32'd1);
      for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_log("ovf_r0w0", 0, 32'hA5000000);
      chk_log("ovf_r0w1", 1, 32'd7);
      chk_log("ovf_r1w0", 4, 32'hA5010000);
      chk_log("ovf_r1w1", 5, 32'd15);
      chk_log("ovf_r2w1", 9, 32'd23);
      chk_log("ovf_r3w0", 12, 32'hA5030000);
      chk_log("ovf_r3w1", 13, 32'd31);
      chk_log("ovf_r4w0", 16, 32'hA5040004);
      chk_log("ovf_r4w1", 17, 32'd71);
      // randomized events, pc and backpressure
      do_reset();
      for (int i = 0; i < 400; i++) begin
         start_i = ($urandom_range(7) != 0);
         tx.ready = $urandom_range(1);
         stall_i = $urandom_range(1);
         branch_i = ($urandom_range(3) == 0);
         flush_i = ($urandom_range(3) == 0);
         pc_i = $urandom;
         step();
      end
      k = 0;
      while ((exp_q.size() > 0 || tx.valid === 1'b1) && k < 200) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         k++;
      end
      chk("rand_drained", 32'(exp_q.size()), 32'd0);
      // reset while the second record's w2 is on the bus
      do_reset();
      k = 0;
      while (n_words < 6 && k < 100) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         k++;
      end
      chk("mid_reached", 32'(n_words), 32'd6);
      rst_i = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      rst_i = 1'b0;
      log_q.delete();
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_log("mid_w0", 0, 32'hA5000000);
      chk_log("mid_w1", 1, 32'd7);
      chk_log("mid_w2", 2, 32'd28);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
